conv_encoder_stream: RTL and testbench
======================================

// Module: conv_encoder_stream
// PURPOSE
//  Streaming convolutional encoder, runtime-configurable rate (1/2, 1/3) and constraint length (K=3/5/7/9).
//  Accepts one info bit per handshake and emits one MAX_CODE_RATE-bit code symbol per bit.
//  Appends K-1 zero tail bits per frame (trellis termination) so the Viterbi decoder starts/ends in state 0.
//  Sits between the frame source and the channel/decoder path of endec; replaces the fixed single-bit encoder.
// PARAMETERS
//  MAX_K      9   max constraint length; shift register / polynomial width
//  MAX_N      3   max symbols per input bit (rate 1/MAX_N)
//  LEN_W      16  width of frame-length field
// PORTS
//  sys_clk        in   1          clock, all logic on rising edge
//  rst            in   1          synchronous reset, active-high; overrides en
//  en             in   1          clock enable; low = all state/outputs frozen
//  i_code_rate    in   1          0 = rate 1/2 (poly 0,1), 1 = rate 1/3 (poly 0,1,2)
//  i_constr_len   in   2          0:K=3 1:K=5 2:K=7 3:K=9
//  i_gen_poly     in   MAX_N*MAX_K  poly j at [j*MAX_K +: MAX_K]; bit 0 taps current bit, bit i taps bit delayed i
//  i_frame_len    in   LEN_W      info bits in frame (0 = tail only)
//  i_start        in   1          frame start request, sampled in IDLE only
//  s_valid        in   1          info bit valid
//  s_ready        out  1          encoder accepts info bit
//  s_bit          in   1          info bit
//  m_valid        out  1          code symbol valid
//  m_ready        in   1          sink accepts code symbol
//  m_data         out  MAX_N      m_data[j] = parity of poly j; unused lanes forced 0
//  m_last         out  1          marks final tail symbol of frame
//  o_busy         out  1          high in DATA/TAIL/FLUSH
//  o_done         out  1          one-cycle pulse when frame fully delivered
// BEHAVIOUR
//  Reset: state IDLE, shift reg 0, counters 0, s_ready/m_valid/m_last/o_busy/o_done = 0, m_data = 0.
//  en low: no state, register or output change; handshakes are not counted.
//  FSM: IDLE -> (i_start) DATA, or TAIL if i_frame_len==0; latch rate, K, polys, frame_len; clear shift reg.
//   DATA: accept bits until frame_len accepted -> TAIL. TAIL: issue K-1 zero bits -> FLUSH.
//   FLUSH: wait for last symbol (m_last) to be taken -> pulse o_done, -> IDLE.
//  Config inputs are ignored outside IDLE; i_start ignored when not IDLE.
//  Handshake: transfer when valid&&ready same cycle. s_ready = (state==DATA) && (!m_valid || m_ready).
//  Output register: one entry; accepted bit b produces symbol with m_valid next cycle (latency 1).
//   Full throughput: 1 symbol/cycle when m_ready held high.
//  Backpressure: while m_valid && !m_ready, m_data/m_last held stable, no new bit accepted or tail issued.
//  TAIL bits issued under same slot rule as s_ready (no s_valid needed).
//  Encoding: window w = {sreg[K-2:0], b} (bit 0 = b); m_data[j] = ^(w & poly_j & mask_K);
//   mask_K keeps bits [K-1:0]; poly bits >= K ignored. sreg shifts in b after each transfer.
//  m_data[2] = 0 at rate 1/2; m_data stays 0 when m_valid low after reset; else holds last value.
//  m_last high only with the (K-1)-th tail symbol.
//  Counters: bit counter LEN_W wide, saturate-free (compared to latched frame_len); tail counter 3 bits.
//  Back-to-back: i_start in the cycle o_done is high is ignored; earliest restart next cycle.
//  rst mid-frame: abandon frame immediately, outputs to reset values, no o_done.
// TESTING
//  K=3, polys 7/5 (3'b111,3'b101), rate 1/2, frame_len 4, bits 1,0,1,1, m_ready=1
//   -> (m_data[0],m_data[1]) = 11,10,00,01,01,11; m_last on 6th; o_done 1 cycle later.
//  Same frame, m_ready toggled 1/0 each cycle -> identical symbol sequence, m_data stable while stalled.
//  K=9, polys 557/663 octal (9'b111101101, 9'b110011011), rate 1/2, frame_len 1, bit 1
//   -> 9 symbols, first = 11, last 8 are tail, m_last only on 9th.
//  Rate 1/3, K=3, polys 7/7/5, bit 1 -> first symbol m_data = 3'b111; rate 1/2 same -> m_data[2]=0.
//  frame_len 0, K=5 -> 4 all-zero tail symbols, s_ready never asserted, o_done pulses.
//  rst asserted mid-DATA (after 2 of 4 bits) -> next cycle IDLE, m_valid=0, no o_done; en=0 for 3 cycles mid-frame -> no change.

Source files
------------

// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder with runtime rate (1/2, 1/3) and constraint length (K=3..9).
// Each frame of info bits is followed by K-1 zero tail bits so the decoder trellis ends in state 0.
//
// state | meaning
// IDLE  | waiting for i_start, configuration inputs are live
// DATA  | accepting frame_len info bits from the source
// TAIL  | issuing K-1 zero tail bits, no source handshake
// FLUSH | waiting for the sink to take the final tail symbol
module conv_encoder_stream #(
   parameter int MAX_K = 9,
   parameter int MAX_N = 3,
   parameter int LEN_W = 16
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   i_code_rate,
   input  logic [1:0]             i_constr_len,
   input  logic [MAX_N*MAX_K-1:0] i_gen_poly,
   input  logic [LEN_W-1:0]       i_frame_len,
   input  logic                   i_start,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic                   s_bit,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [MAX_N-1:0]       m_data,
   output logic                   m_last,
   output logic                   o_busy,
   output logic                   o_done
);

   typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

   state_t                   state, state_nxt;
   logic [MAX_K-2:0]         sreg;
   logic [LEN_W-1:0]         bit_cnt;
   logic [2:0]               tail_cnt;
   logic                     rate_q;
   logic [1:0]               k_q;
   logic [MAX_N*MAX_K-1:0]   poly_q;
   logic [LEN_W-1:0]         len_q;

   logic                     slot_free;
   logic                     start_go;
   logic                     data_xfer;
   logic                     tail_xfer;
   logic                     last_bit;
   logic                     tail_last;
   logic                     fin;
   logic                     b_in;
   logic [MAX_K-1:0]         win;
   logic [MAX_K-1:0]         mask_k;
   logic [MAX_N-1:0]         enc;

   assign slot_free = !m_valid || m_ready;
   // A restart is refused in the o_done cycle so every frame gets a visible idle gap.
   assign start_go  = (state == IDLE) && i_start && !o_done;
   assign data_xfer = s_valid && s_ready;
   assign tail_xfer = (state == TAIL) && slot_free;
   assign last_bit  = (bit_cnt + LEN_W'(1)) == len_q;
   // Index of the final tail bit is K-2 = 2*k_q+1.
   assign tail_last = tail_cnt == {k_q, 1'b1};
   assign fin       = (state == FLUSH) && m_valid && m_ready && m_last;
   assign b_in      = (state == DATA) ? s_bit : 1'b0;
   assign win       = {sreg, b_in};

   always_comb begin
      int k_len;
      k_len = 2 * int'(k_q) + 3;
      mask_k = '0;
      for (int i = 0; i < MAX_K; i++) begin
         mask_k[i] = (i < k_len);
      end
   end

   always_comb begin
      logic lane_en;
      enc = '0;
      lane_en = 1'b0;
      for (int j = 0; j < MAX_N; j++) begin
         lane_en = (j < 2) || ((j == 2) && rate_q);
         enc[j]  = lane_en & (^(win & poly_q[j*MAX_K +: MAX_K] & mask_k));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_go) state_nxt = (i_frame_len == '0) ? TAIL : DATA;
         DATA:    if (data_xfer && last_bit) state_nxt = TAIL;
         TAIL:    if (tail_xfer && tail_last) state_nxt = FLUSH;
         FLUSH:   if (fin) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == DATA) && slot_free;
      o_busy  = (state != IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sreg     <= '0;
         bit_cnt  <= '0;
         tail_cnt <= '0;
         rate_q   <= 1'b0;
         k_q      <= '0;
         poly_q   <= '0;
         len_q    <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         o_done   <= 1'b0;
      end else if (en) begin
         o_done <= fin;
         if (start_go) begin
            rate_q   <= i_code_rate;
            k_q      <= i_constr_len;
            poly_q   <= i_gen_poly;
            len_q    <= i_frame_len;
            sreg     <= '0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
         end
         if (data_xfer || tail_xfer) begin
            sreg    <= {sreg[MAX_K-3:0], b_in};
            m_valid <= 1'b1;
            m_data  <= enc;
            m_last  <= tail_xfer && tail_last;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (data_xfer) bit_cnt <= bit_cnt + LEN_W'(1);
         if (tail_xfer) tail_cnt <= tail_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed bench for conv_encoder_stream: expected symbols are queued at frame start
// and compared as the sink accepts them.
module tb_conv_encoder_stream;
   localparam int MAX_K = 9;
   localparam int MAX_N = 3;
   localparam int LEN_W = 16;

   logic                   sys_clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   en = 1'b1;
   logic                   i_code_rate = 1'b0;
   logic [1:0]             i_constr_len = '0;
   logic [MAX_N*MAX_K-1:0] i_gen_poly = '0;
   logic [LEN_W-1:0]       i_frame_len = '0;
   logic                   i_start = 1'b0;
   logic                   s_valid = 1'b0;
   logic                   s_bit = 1'b0;
   logic                   s_ready;
   logic                   m_valid;
   logic                   m_ready = 1'b1;
   logic [MAX_N-1:0]       m_data;
   logic                   m_last;
   logic                   o_busy;
   logic                   o_done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_cyc = -1;
   int done_cnt = 0;
   bit tog = 1'b0;
   bit tog_ph = 1'b0;
   bit sr_seen = 1'b0;
   logic [3:0] sb[$];

   conv_encoder_stream #(.MAX_K(MAX_K), .MAX_N(MAX_N), .LEN_W(LEN_W)) dut (
      .sys_clk(sys_clk), .rst(rst), .en(en), .i_code_rate(i_code_rate),
      .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_frame_len(i_frame_len),
      .i_start(i_start), .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc++;

   always @(posedge sys_clk) begin
      #1;
      tog_ph = ~tog_ph;
      m_ready = tog ? tog_ph : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] held;
   bit stalled = 1'b0;
   always @(negedge sys_clk) begin
      if (o_done) done_cnt++;
      if (s_ready) sr_seen = 1'b1;
      if (!rst && en) begin
         if (stalled && m_valid) chk("stall_hold", 32'({m_last, m_data}), 32'(held));
         stalled = 1'b0;
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_sym", 32'({m_last, m_data}), 32'hDEAD);
            end else begin
               chk("sym", 32'({m_last, m_data}), 32'(sb.pop_front()));
               if (m_last) last_cyc = cyc;
            end
         end else if (m_valid) begin
            stalled = 1'b1;
            held = {m_last, m_data};
         end
      end
   end

   // Reference encoder: history holds past inputs, bit t = input delayed t.
   task automatic model(input int k, input bit rate, input logic [26:0] polys,
                        input int len, input logic [15:0] bits);
      logic [8:0] hist;
      hist = '0;
      for (int i = 0; i < len + k - 1; i++) begin
         logic b;
         logic [2:0] d;
         b = (i < len) ? bits[i] : 1'b0;
         hist = {hist[7:0], b};
         d = '0;
         for (int j = 0; j < (rate ? 3 : 2); j++)
            for (int t = 0; t < k; t++)
               d[j] = d[j] ^ (hist[t] & polys[j*9 + t]);
         sb.push_back({(i == len + k - 2), d});
      end
   endtask

   task automatic start(input bit rate, input int k, input logic [26:0] polys, input int len);
      @(posedge sys_clk); #1;
      i_code_rate = rate;
      i_constr_len = 2'((k - 3) / 2);
      i_gen_poly = polys;
      i_frame_len = 16'(len);
      i_start = 1'b1;
      @(posedge sys_clk); #1;
      i_start = 1'b0;
      i_code_rate = ~rate;
      i_constr_len = ~i_constr_len;
      i_gen_poly = '0;
      i_frame_len = 16'd7;
   endtask

   task automatic send_bit(input logic b);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_bit = b;
      @(negedge sys_clk);
      while (!(s_ready && en) && t < 60) begin
         @(negedge sys_clk);
         t++;
      end
      chk("send_timeout", 32'(t < 60), 32'd1);
      @(posedge sys_clk); #1;
      s_valid = 1'b0;
      s_bit = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit chk_lat);
      int t;
      t = 0;
      @(negedge sys_clk);
      while (!o_done && t < 200) begin
         @(negedge sys_clk);
         t++;
      end
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      if (chk_lat) chk({tag, "_done_lat"}, 32'(cyc - last_cyc), 32'd1);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge sys_clk);
      chk({tag, "_done_pulse"}, 32'({o_done, o_busy}), 32'd0);
   endtask

   initial begin
      logic [4:0] snap;
      int dc;

      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("reset_outs", 32'({s_ready, m_valid, m_last, o_busy, o_done}), 32'd0);
      chk("reset_data", 32'(m_data), 32'd0);
      @(posedge sys_clk); #1;
      rst = 1'b0;

      // K=3, 7/5, rate 1/2, bits 1,0,1,1
      sb.push_back(4'b0011); sb.push_back(4'b0001); sb.push_back(4'b0000);
      sb.push_back(4'b0010); sb.push_back(4'b0010); sb.push_back(4'b1011);
      start(1'b0, 3, {9'd0, 9'o5, 9'o7}, 4);
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      wait_done("k3", 1'b1);

      // same frame under alternating backpressure
      tog = 1'b1;
      sb.push_back(4'b0011); sb.push_back(4'b0001); sb.push_back(4'b0000);
      sb.push_back(4'b0010); sb.push_back(4'b0010); sb.push_back(4'b1011);
      start(1'b0, 3, {9'd0, 9'o5, 9'o7}, 4);
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      wait_done("k3_bp", 1'b0);
      tog = 1'b0;

      // K=9, 557/663, single bit 1: first symbol 11 then 8 tail symbols
      sb.push_back(4'b0011);
      model(9, 1'b0, {9'd0, 9'b110011011, 9'b111101101}, 1, 16'h1);
      void'(sb.pop_back());
      sb.delete(1);
      begin
         logic [3:0] tmp[$];
         tmp = sb;
         sb.delete();
         sb.push_back(4'b0011);
         model(9, 1'b0, {9'd0, 9'b110011011, 9'b111101101}, 1, 16'h1);
         void'(sb.pop_front());
      end
      start(1'b0, 9, {9'd0, 9'b110011011, 9'b111101101}, 1);
      send_bit(1);
      wait_done("k9", 1'b1);

      // rate 1/3, K=3, 7/7/5, bit 1
      sb.push_back(4'b0111); sb.push_back(4'b0011); sb.push_back(4'b1111);
      start(1'b1, 3, {9'o5, 9'o7, 9'o7}, 1);
      send_bit(1);
      wait_done("r13", 1'b1);

      // same polys at rate 1/2: lane 2 must stay 0
      sb.push_back(4'b0011); sb.push_back(4'b0011); sb.push_back(4'b1011);
      start(1'b0, 3, {9'o5, 9'o7, 9'o7}, 1);
      send_bit(1);
      wait_done("r12", 1'b1);

      // empty frame, K=5: tail only
      sr_seen = 1'b0;
      sb.push_back(4'b0000); sb.push_back(4'b0000); sb.push_back(4'b0000); sb.push_back(4'b1000);
      start(1'b0, 5, {9'd0, 9'o23, 9'o31}, 0);
      wait_done("len0", 1'b1);
      chk("len0_no_sready", 32'(sr_seen), 32'd0);

      // clock-enable freeze mid-frame, K=7
      model(7, 1'b1, {9'o155, 9'o171, 9'o133}, 4, 16'b1011);
      start(1'b1, 7, {9'o155, 9'o171, 9'o133}, 4);
      send_bit(1); send_bit(1);
      en = 1'b0;
      s_valid = 1'b1;
      s_bit = 1'b0;
      @(negedge sys_clk);
      snap = {m_valid, m_last, o_busy, s_ready, o_done};
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         chk("en_freeze_ctl", 32'({m_valid, m_last, o_busy, s_ready, o_done}), 32'(snap));
         chk("en_freeze_busy", 32'(o_busy), 32'd1);
      end
      @(posedge sys_clk); #1;
      en = 1'b1;
      send_bit(0); send_bit(1);
      wait_done("en", 1'b1);

      // synchronous reset after 2 of 4 bits
      model(3, 1'b0, {9'd0, 9'o5, 9'o7}, 4, 16'b1101);
      start(1'b0, 3, {9'd0, 9'o5, 9'o7}, 4);
      send_bit(1); send_bit(0);
      rst = 1'b1;
      sb.delete();
      dc = done_cnt;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_mid_outs", 32'({o_busy, m_valid, m_last, s_ready}), 32'd0);
      chk("rst_mid_data", 32'(m_data), 32'd0);
      repeat (5) @(negedge sys_clk);
      chk("rst_mid_no_done", 32'(done_cnt - dc), 32'd0);
      chk("rst_mid_idle", 32'(o_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
